// File: rtl/prng_arbiter_pkg.sv
// rtl/prng_arbiter_pkg.sv - shared types and register offsets for prng_arbiter
package prng_arbiter_pkg;

  // Sequencer states: advance-write to CTRL, then read of RDATA
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADV_REQ = 3'd1,
    ST_ADV_RSP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RSP  = 3'd4
  } prng_arb_state_e;

  // Byte offsets of the PRNG slave registers
  localparam logic [3:0] PRNG_CTRL_OFFSET  = 4'h0;
  localparam logic [3:0] PRNG_RDATA_OFFSET = 4'h4;

  // Default OBI ID width of the subordinate port
  localparam int unsigned PRNG_OBI_ID_WIDTH = 1;

endpackage

// File: rtl/prng_arbiter_rr_arbiter.sv
// rtl/prng_arbiter_rr_arbiter.sv - combinational round-robin pick starting after the last winner
module rr_arbiter
  import prng_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan last+1 .. last+NUM_REQ (mod NUM_REQ); first active request wins
  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/prng_arbiter.sv
// rtl/prng_arbiter.sv - shares one xorshift OBI slave among NUM_REQ requesters; PRNG_ARBITER_PREFETCH_EN adds a one-entry prefetch buffer
module prng_arbiter
  import prng_arbiter_pkg::*;
#(
  parameter int unsigned               NUM_REQ        = 4,
  parameter int unsigned               ADDR_WIDTH_OBI = 32,
  parameter int unsigned               DATA_WIDTH_OBI = 32,
  parameter int unsigned               ID_WIDTH_OBI   = PRNG_OBI_ID_WIDTH,
  parameter logic [ADDR_WIDTH_OBI-1:0] PRNG_BASE_ADDR = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic [DATA_WIDTH_OBI-1:0] rnd_o,
  output logic                      err_o,
  output logic                      obi_req_o,
  output logic                      obi_we_o,
  output logic [3:0]                obi_be_o,
  output logic [ADDR_WIDTH_OBI-1:0] obi_addr_o,
  output logic [DATA_WIDTH_OBI-1:0] obi_wdata_o,
  output logic [ID_WIDTH_OBI-1:0]   obi_aid_o,
  input  logic                      obi_gnt_i,
  input  logic                      obi_rvalid_i,
  input  logic                      obi_err_i,
  input  logic [DATA_WIDTH_OBI-1:0] obi_rdata_i,
  input  logic [ID_WIDTH_OBI-1:0]   obi_rid_i
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [ADDR_WIDTH_OBI-1:0] CTRL_ADDR =
    PRNG_BASE_ADDR + ADDR_WIDTH_OBI'(PRNG_CTRL_OFFSET);
  localparam logic [ADDR_WIDTH_OBI-1:0] RDATA_ADDR =
    PRNG_BASE_ADDR + ADDR_WIDTH_OBI'(PRNG_RDATA_OFFSET);

  prng_arb_state_e state_q, state_d;

  logic [IDX_W-1:0]          last_q, last_d;
  logic [NUM_REQ-1:0]        ack_q, ack_d;
  logic [DATA_WIDTH_OBI-1:0] rnd_q, rnd_d;
  logic                      err_q, err_d;

  logic                      any_req;
  logic [NUM_REQ-1:0]        win_gnt;
  logic [IDX_W-1:0]          win_idx;

  // A finished sequence: errored advance, or the read response
  logic                      cmp_vld;
  logic [DATA_WIDTH_OBI-1:0] cmp_data;

`ifdef PRNG_ARBITER_PREFETCH_EN
  logic [DATA_WIDTH_OBI-1:0] buf_q, buf_d;
  logic                      buf_vld_q, buf_vld_d;
  logic                      buf_err_q, buf_err_d;
  logic                      unused_inputs;
  assign unused_inputs = ^obi_rid_i;
`else
  logic [IDX_W-1:0]          sel_q, sel_d;
  logic                      unused_inputs;
  assign unused_inputs = ^{obi_rid_i, win_gnt};
`endif

  assign any_req  = |req_i;
  assign cmp_vld  = obi_rvalid_i &&
                    ((state_q == ST_RD_RSP) || ((state_q == ST_ADV_RSP) && obi_err_i));
  assign cmp_data = obi_err_i ? '0 : obi_rdata_i;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req  (req_i),
    .last (last_q),
    .gnt  (win_gnt),
    .idx  (win_idx)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; an errored advance skips the read entirely
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
`ifdef PRNG_ARBITER_PREFETCH_EN
        if (!buf_vld_q || any_req) state_d = ST_ADV_REQ;
`else
        if (any_req) state_d = ST_ADV_REQ;
`endif
      end
      ST_ADV_REQ: if (obi_gnt_i) state_d = ST_ADV_RSP;
      ST_ADV_RSP: if (obi_rvalid_i) state_d = obi_err_i ? ST_IDLE : ST_RD_REQ;
      ST_RD_REQ:  if (obi_gnt_i) state_d = ST_RD_RSP;
      ST_RD_RSP:  if (obi_rvalid_i) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: OBI request phase is a pure decode of the state, so it is stable until granted
  always_comb begin
    obi_req_o   = 1'b0;
    obi_we_o    = 1'b0;
    obi_addr_o  = '0;
    obi_be_o    = 4'hF;
    obi_wdata_o = '0;
    obi_aid_o   = '0;
    if (state_q == ST_ADV_REQ) begin
      obi_req_o  = 1'b1;
      obi_we_o   = 1'b1;
      obi_addr_o = CTRL_ADDR;
    end else if (state_q == ST_RD_REQ) begin
      obi_req_o  = 1'b1;
      obi_addr_o = RDATA_ADDR;
    end
  end

  // Datapath next values: ack/rnd/err are single-cycle, zero when idle
  always_comb begin
    ack_d  = '0;
    rnd_d  = '0;
    err_d  = 1'b0;
    last_d = last_q;
`ifdef PRNG_ARBITER_PREFETCH_EN
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    buf_err_d = buf_err_q;
    if ((state_q == ST_IDLE) && buf_vld_q && any_req) begin
      ack_d     = win_gnt;
      rnd_d     = buf_q;
      err_d     = buf_err_q;
      last_d    = win_idx;
      buf_vld_d = 1'b0;
    end
    // At fill end a waiting requester takes the number directly; otherwise it is parked
    if (cmp_vld) begin
      if (any_req) begin
        ack_d  = win_gnt;
        rnd_d  = cmp_data;
        err_d  = obi_err_i;
        last_d = win_idx;
      end else begin
        buf_d     = cmp_data;
        buf_err_d = obi_err_i;
        buf_vld_d = 1'b1;
      end
    end
`else
    sel_d = sel_q;
    if ((state_q == ST_IDLE) && any_req) begin
      sel_d = win_idx;
    end
    if (cmp_vld) begin
      ack_d  = NUM_REQ'(1) << sel_q;
      rnd_d  = cmp_data;
      err_d  = obi_err_i;
      last_d = sel_q;
    end
`endif
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q    <= LAST_RST;
      ack_q     <= '0;
      rnd_q     <= '0;
      err_q     <= 1'b0;
`ifdef PRNG_ARBITER_PREFETCH_EN
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
      buf_err_q <= 1'b0;
`else
      sel_q     <= '0;
`endif
    end else begin
      last_q    <= last_d;
      ack_q     <= ack_d;
      rnd_q     <= rnd_d;
      err_q     <= err_d;
`ifdef PRNG_ARBITER_PREFETCH_EN
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      buf_err_q <= buf_err_d;
`else
      sel_q     <= sel_d;
`endif
    end
  end

  assign ack_o = ack_q;
  assign rnd_o = rnd_q;
  assign err_o = err_q;

endmodule

// File: doc/prng_arbiter.md
# prng_arbiter

Round-robin scheduler that shares one `xorshift` PRNG slave among `NUM_REQ` hardware requesters. It sits in the user domain between the requesters and the PRNG's OBI slave port, acting as an OBI master. For each granted request it sequences two transactions, an advance-write to `CTRL` and then a read of `RDATA`, and returns the fresh number to that requester only.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16)
- `ADDR_WIDTH_OBI`, 32, OBI address width
- `DATA_WIDTH_OBI`, 32, OBI data width; also the random-number width
- `ID_WIDTH_OBI`, `SbrObiCfg.IdWidth`, OBI ID width
- `PRNG_BASE_ADDR`, 32'h0, byte base address of the PRNG slave
- `clk_i` in 1 — the single clock
- `rst_ni` in 1 — reset, asynchronous, active-low
- `req_i` in NUM_REQ — per-requester level request; held until the matching `ack_o` bit
- `ack_o` out NUM_REQ — one-hot, single-cycle completion pulse
- `rnd_o` out DATA_WIDTH_OBI — number for the acked requester; valid only while `ack_o` is nonzero
- `err_o` out 1 — qualifies `ack_o`: the transaction failed and `rnd_o` = 0
- `obi_req_o`, `obi_we_o` out 1 — OBI master request and write-enable
- `obi_be_o` out 4 — always 4'hF
- `obi_addr_o` out ADDR_WIDTH_OBI — OBI address
- `obi_wdata_o` out DATA_WIDTH_OBI — always 0
- `obi_aid_o` out ID_WIDTH_OBI — always 0
- `obi_gnt_i`, `obi_rvalid_i`, `obi_err_i` in 1 — OBI grant, response valid, response error
- `obi_rdata_i` in DATA_WIDTH_OBI — OBI read data
- `obi_rid_i` in ID_WIDTH_OBI — OBI response ID; ignored

## Operation
- FSM states: IDLE → ADV_REQ → ADV_RSP → RD_REQ → RD_RSP → IDLE.
- IDLE: if any `req_i` bit is set, latch the round-robin winner in `sel_q` and go to ADV_REQ.
  - The search starts at `last_q+1` mod NUM_REQ.
  - `last_q` resets to NUM_REQ-1, so requester 0 wins first.
- ADV_REQ: drive `obi_req_o`=1, `obi_we_o`=1, `obi_addr_o`=BASE+0x0. Hold until `obi_gnt_i`, then go to ADV_RSP.
- ADV_RSP: drive `obi_req_o`=0 and wait for `obi_rvalid_i`.
  - If `obi_err_i` is set: go to IDLE and issue an error ack.
  - Otherwise: go to RD_REQ.
- RD_REQ: drive `obi_req_o`=1, `obi_we_o`=0, `obi_addr_o`=BASE+0x4. Hold until `obi_gnt_i`, then go to RD_RSP.
- RD_RSP: on `obi_rvalid_i`, register `rnd_o`=`obi_rdata_i` (0 if `obi_err_i`), `err_o`=`obi_err_i`, `ack_o`=onehot(`sel_q`), and `last_q`=`sel_q`. Then go to IDLE.
- OBI address/we/be are stable while `obi_req_o` is high and the grant has not arrived.
- A requester dropping `req_i` mid-sequence does not abort the sequence. The ack is still issued; the PRNG still advanced.
- New requests arriving during a sequence wait. Arbitration happens only in IDLE (or at fill end, see Configuration).
- Reset mid-operation: all state returns to reset values and `obi_req_o` drops immediately. An outstanding OBI response is ignored.
- Reset values:
  - Outputs: `ack_o`=0, `rnd_o`=0, `err_o`=0, `obi_req_o`=0, `obi_we_o`=0, `obi_addr_o`=0.
  - Internal: state IDLE, `sel_q`=0.

## Timing
- `ack_o`, `rnd_o`, `err_o` are registered.
- With a zero-wait slave (gnt same cycle, rvalid next cycle): request seen in IDLE at cycle 0 → `ack_o` high at cycle 5.
- Back-to-back service: the next winner is picked in the IDLE cycle that follows the ack-setting edge, giving 5 cycles per number.
- Fairness: any continuously requesting port is served within NUM_REQ sequences.

## Configuration
- `PRNG_ARBITER_PREFETCH_EN` defined:
  - Adds a one-entry buffer (`buf_q`, `buf_vld_q`), reset invalid.
  - The FSM fills the buffer autonomously after reset and after every consumption; fill uses the same four states.
  - In IDLE with `buf_vld_q`=1 and a winner: ack next cycle (latency 1) with `buf_q`, clear `buf_vld_q`, start a refill.
  - A fill error sets `err_o` on the next ack served from the buffer.
- Macro undefined: no buffer; every request runs the full sequence as above.

## Structure
- Package `prng_arbiter_pkg`: FSM state enum `prng_arb_state_e`, offsets `PRNG_CTRL_OFFSET`=4'h0 and `PRNG_RDATA_OFFSET`=4'h4.
- Sub-module `rr_arbiter` (parameter NUM_REQ): inputs `req`, `last`; output one-hot `gnt` plus `idx`; purely combinational.

## Test plan
- Single request: `req_i`=4'b0001 against the real `xorshift` (seed 32'hDEADBEEF) → `ack_o`=4'b0001 at cycle 5; `rnd_o` equals the golden xorshift32 of 32'hDEADBEEF; `err_o`=0.
- All four requesting from cycle 0, held → acks in order 0,1,2,3 at cycles 5,10,15,20; `rnd_o` matches four consecutive golden states.
- Slave stub inserting 3 wait cycles on `obi_gnt_i` → address/we held stable; ack at cycle 11.
- Stub returning `obi_err_i` on ADV response → `ack_o` with `err_o`=1, `rnd_o`=0, no read issued; next request proceeds normally.
- `rst_ni` low during RD_RSP → `obi_req_o`=0, no ack; after release, requester 0 is served first.
- Macro defined: after the fill completes, `req_i`=4'b0100 → ack on the next cycle with the buffered value; refill starts on the following cycle.
